soc_event_queue: RTL
====================

SOC_EVENT_QUEUE -- requirements
Module: soc_event_queue

Interface
REQ-001 Parameter NB_EVENTS, default 32, SHALL set the number of peripheral event lines.
REQ-002 Parameter EVENT_ID_WIDTH, default 8, SHALL set the width of the event ID sent to the FC event FIFO.
REQ-003 Parameter ID_OFFSET, default 0, SHALL be added to the line index to form the event ID.
REQ-004 Parameter DEPTH, default 4, power of two >= 2, SHALL set the internal queue depth.
REQ-005 clk_i  in  1  single clock; all state SHALL be on its rising edge.
REQ-006 rst_i  in  1  reset, asynchronous, active-high.
REQ-007 events_i  in  NB_EVENTS  single-cycle event pulses, one per peripheral line.
REQ-008 mask_i  in  NB_EVENTS  1 = line enabled, 0 = line ignored.
REQ-009 event_fifo_valid_o  out  1  queue head valid towards the FC event FIFO.
REQ-010 event_fifo_data_o  out  EVENT_ID_WIDTH  queue head event ID.
REQ-011 event_fifo_fulln_i  in  1  downstream FIFO not full (ready).
REQ-012 pending_o  out  NB_EVENTS  per-line pending bits.
REQ-013 lost_o  out  1  one-cycle pulse, an event occurrence was dropped.
REQ-014 lost_cnt_o  out  8  saturating count of dropped occurrences.

Function
REQ-015 Each line SHALL own a pending bit, set at the clock edge ending any cycle where events_i[i] & mask_i[i] = 1.
REQ-016 An event on a line with mask_i[i] = 0 SHALL be ignored, with no pending set and no loss counted; clearing a mask SHALL NOT clear an already-set pending bit.
REQ-017 Each cycle, if queue count < DEPTH and any pending bit is set, the arbiter SHALL grant one line: the first set bit scanning upward from rr_ptr, wrapping at NB_EVENTS-1 to 0.
REQ-018 On grant of line g:
- the pending bit g SHALL clear;
- ID = (g + ID_OFFSET) truncated to EVENT_ID_WIDTH SHALL be written to the queue tail;
- rr_ptr SHALL become (g+1) mod NB_EVENTS.
REQ-019 If line g is granted and events_i[g] & mask_i[g] = 1 in the same cycle, pending[g] SHALL remain set, with no loss counted.
REQ-020 If pending[i] is set, not granted, and events_i[i] & mask_i[i] = 1, the occurrence SHALL be dropped:
- lost_o SHALL be 1 in the next cycle;
- lost_cnt_o SHALL increment by 1, saturating at 255.
REQ-021 Simultaneous drops on multiple lines in one cycle SHALL increment lost_cnt_o by 1 only.
REQ-022 The full condition SHALL use the registered count: with count = DEPTH, no grant occurs even if a pop happens in the same cycle.
REQ-023 event_fifo_valid_o SHALL equal (count != 0), driven from registers; event_fifo_data_o SHALL be the queue head.
REQ-024 A pop SHALL occur when event_fifo_valid_o & event_fifo_fulln_i = 1; data SHALL stay stable while valid and not popped.
REQ-025 A simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-026 Latency: an event pulse in cycle t, with the queue empty and the line pending-free, SHALL appear as event_fifo_valid_o = 1 in cycle t+2.
REQ-027 Throughput: one grant per cycle and one pop per cycle SHALL be sustained.

Reset
REQ-028 While rst_i = 1, the following SHALL be zero: all pending bits, rr_ptr, queue pointers, count, event_fifo_valid_o, event_fifo_data_o, lost_o and lost_cnt_o.
REQ-029 Reset asserted mid-operation SHALL discard queued and pending events with no pop issued; operation SHALL restart from rr_ptr = 0.

Verification
REQ-030 Scenario: pulse events_i[3], mask all ones, fulln = 1, ID_OFFSET = 0 -> valid at t+2 with data 0x03, popped, then valid = 0.
REQ-031 Scenario: pulse lines 5, 1 and 30 in one cycle, rr_ptr = 0 -> output order 1, 5, 30, with rr_ptr = 31 afterwards.
REQ-032 Scenario: fulln = 0, pulse 6 distinct lines, DEPTH = 4 -> count = 4, two pending bits remain, valid held with the first ID stable; on releasing fulln, all 6 IDs are delivered in round-robin order.
REQ-033 Scenario: with fulln = 0 and the queue full, pulse line 2 twice -> lost_o pulses once and lost_cnt_o = 1; with 300 repeated drops, lost_cnt_o = 255.
REQ-034 Scenario: mask_i[7] = 0 and pulse line 7 -> no pending, no output, no loss; then set pending on line 9, clear mask_i[9] -> ID 9 is still delivered.
REQ-035 Scenario: assert rst_i while the queue holds 3 entries -> valid = 0 within the reset cycle and all counters zero; after release, a new event on line 0 outputs 0x00 at t+2.

Source files
------------

// File: rtl/soc_event_queue.sv
// soc_event_queue
// Collects single-cycle peripheral event pulses into per-line pending bits.
// A round-robin arbiter moves one pending line per cycle into a small queue
// of event IDs, which drains towards the FC event FIFO with valid/ready
// handshaking. Occurrences arriving on a line that is already pending are
// dropped and counted.

module soc_event_queue #(
   parameter int NB_EVENTS      = 32,
   parameter int EVENT_ID_WIDTH = 8,
   parameter int ID_OFFSET      = 0,
   parameter int DEPTH          = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NB_EVENTS-1:0]      events_i,
   input  logic [NB_EVENTS-1:0]      mask_i,
   output logic                      event_fifo_valid_o,
   output logic [EVENT_ID_WIDTH-1:0] event_fifo_data_o,
   input  logic                      event_fifo_fulln_i,
   output logic [NB_EVENTS-1:0]      pending_o,
   output logic                      lost_o,
   output logic [7:0]                lost_cnt_o
);

   localparam int PTR_W = (NB_EVENTS > 1) ? $clog2(NB_EVENTS) : 1;
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;

   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [NB_EVENTS-1:0]      pending_q, pending_d;
   logic [NB_EVENTS-1:0]      ev_valid;
   logic [NB_EVENTS-1:0]      grant_vec;
   logic [NB_EVENTS-1:0]      drop_vec;
   logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]          grant_idx;
   logic                      grant_found;
   logic                      grant;
   logic                      pop;
   int                        scan_pos;
   logic [EVENT_ID_WIDTH-1:0] grant_id;

   logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]             count_q, count_d;
   logic [EVENT_ID_WIDTH-1:0] mem_q [DEPTH];
   logic [EVENT_ID_WIDTH-1:0] mem_d [DEPTH];
   logic                      valid_q, valid_d;
   logic                      lost_q, lost_d;
   logic [7:0]                lost_cnt_q, lost_cnt_d;

   assign ev_valid = events_i & mask_i;

   // Round-robin search: first pending line at or above rr_ptr, wrapping to line 0.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_pos    = 0;
      for (int off = 0; off < NB_EVENTS; off++) begin
         scan_pos = int'(rr_ptr_q) + off;
         if (scan_pos >= NB_EVENTS) begin
            scan_pos = scan_pos - NB_EVENTS;
         end
         if (!grant_found && pending_q[PTR_W'(scan_pos)]) begin
            grant_found = 1'b1;
            grant_idx   = PTR_W'(scan_pos);
         end
      end
   end

   // Grant only against the registered count so a same-cycle pop never makes room early.
   always_comb begin
      grant     = grant_found && (count_q < FULL_CNT);
      grant_vec = grant ? (NB_EVENTS'(1) << grant_idx) : '0;
      grant_id  = EVENT_ID_WIDTH'(int'(grant_idx) + ID_OFFSET);
      pop       = valid_q && event_fifo_fulln_i;
   end

   // Pending bookkeeping: a granted line is released unless it fires again in the same
   // cycle; a fresh occurrence on a line still waiting is a drop.
   always_comb begin
      drop_vec  = pending_q & ~grant_vec & ev_valid;
      pending_d = (pending_q & ~grant_vec) | ev_valid;
      rr_ptr_d  = rr_ptr_q;
      if (grant) begin
         if (int'(grant_idx) == NB_EVENTS - 1) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = grant_idx + PTR_W'(1);
         end
      end
   end

   // Queue storage and pointers; simultaneous push and pop leaves the count unchanged.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (grant) begin
         mem_d[wr_ptr_q] = grant_id;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({grant, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      valid_d = (count_d != '0);
   end

   // Loss reporting: one pulse and one count step per cycle, however many lines dropped.
   always_comb begin
      lost_d     = |drop_vec;
      lost_cnt_d = lost_cnt_q;
      if (lost_d && (lost_cnt_q != 8'hFF)) begin
         lost_cnt_d = lost_cnt_q + 8'd1;
      end
   end

   // State registers; reset discards everything queued or pending and restarts the search at line 0.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pending_q  <= '0;
         rr_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         valid_q    <= 1'b0;
         lost_q     <= 1'b0;
         lost_cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         pending_q  <= pending_d;
         rr_ptr_q   <= rr_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         valid_q    <= valid_d;
         lost_q     <= lost_d;
         lost_cnt_q <= lost_cnt_d;
         mem_q      <= mem_d;
      end
   end

   assign event_fifo_valid_o = valid_q;
   assign event_fifo_data_o  = mem_q[rd_ptr_q];
   assign pending_o          = pending_q;
   assign lost_o             = lost_q;
   assign lost_cnt_o         = lost_cnt_q;

endmodule
